// File: rtl/intersection_phase_scheduler.sv
// Highway/side-road phase sequencer with dwell timers, ped crossing and emergency preempt.
// Moore outputs decoded from state; cnt clears on every phase change and saturates otherwise.
module intersection_phase_scheduler #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       car_sensor,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [1:0] highway,
    output logic [1:0] small_road,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        PED_WALK  = 3'd3,
        SR_GREEN  = 3'd4,
        SR_YELLOW = 3'd5,
        ALLRED_B  = 3'd6,
        ILLEGAL   = 3'd7
    } state_t;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;

    // Last-cycle values: a state of duration T exits when cnt equals T-1.
    localparam logic [CNT_W-1:0] MIN_END    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_END    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= HW_GREEN;
            cnt      <= '0;
            ped_wait <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_ONE;
            end
            // Entering the walk phase serves the request, even if the button is pressed on that edge.
            if (state_nxt == PED_WALK && state != PED_WALK) begin
                ped_wait <= 1'b0;
            end else if (ped_req) begin
                ped_wait <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        highway    = RED;
        small_road = RED;
        walk       = 1'b0;
        case (state)
            HW_GREEN: begin
                highway = GRN;
                if (cnt >= MIN_END && (car_sensor || ped_wait) && !emerg) begin
                    state_nxt = HW_YELLOW;
                end
            end
            HW_YELLOW: begin
                highway = YEL;
                if (cnt == YELLOW_END) begin
                    state_nxt = ALLRED_A;
                end
            end
            ALLRED_A: begin
                if (cnt == ALLRED_END) begin
                    state_nxt = ped_wait ? PED_WALK : SR_GREEN;
                end
            end
            PED_WALK: begin
                walk = 1'b1;
                if (emerg) begin
                    state_nxt = ALLRED_B;
                end else if (cnt == WALK_END) begin
                    state_nxt = car_sensor ? SR_GREEN : ALLRED_B;
                end
            end
            SR_GREEN: begin
                small_road = GRN;
                if (emerg || (cnt >= MIN_END && !car_sensor) || cnt == MAX_END) begin
                    state_nxt = SR_YELLOW;
                end
            end
            SR_YELLOW: begin
                small_road = YEL;
                if (cnt == YELLOW_END) begin
                    state_nxt = ALLRED_B;
                end
            end
            ALLRED_B: begin
                if (cnt == ALLRED_END) begin
                    state_nxt = HW_GREEN;
                end
            end
            default: begin
                // Unreachable encoding: hold both heads red and recover through a clearance interval.
                state_nxt = ALLRED_B;
            end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench: a table of {inputs, expected phase/ped_wait, repeat count} segments applied cycle by cycle.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       car_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] highway;
    logic [1:0] small_road;
    logic       walk;
    logic       ped_wait;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    intersection_phase_scheduler dut (
        .clk        (clk),
        .clr        (clr),
        .car_sensor (car_sensor),
        .ped_req    (ped_req),
        .emerg      (emerg),
        .highway    (highway),
        .small_road (small_road),
        .walk       (walk),
        .ped_wait   (ped_wait),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       car;
        logic       ped;
        logic       em;
        logic       chk;
        logic [2:0] ph;
        logic       pw;
        int         n;
    } seg_t;

    seg_t segs[$];

    function automatic void add(input logic c, input logic car, input logic ped, input logic em,
                                input logic [2:0] ph, input logic pw, input int n);
        seg_t s;
        s.clr = c; s.car = car; s.ped = ped; s.em = em;
        s.chk = 1'b1; s.ph = ph; s.pw = pw; s.n = n;
        segs.push_back(s);
    endfunction

    function automatic void add_rst();
        seg_t s;
        s.clr = 1'b1; s.car = 1'b0; s.ped = 1'b0; s.em = 1'b0;
        s.chk = 1'b0; s.ph = 3'd0; s.pw = 1'b0; s.n = 1;
        segs.push_back(s);
        add(1, 0, 0, 0, 0, 0, 1);
    endfunction

    task automatic check(input string name, input int seg, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s seg %0d cyc %0d: got %0d expected %0d", name, seg, cyc, act, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_hw;
        logic [1:0] exp_sr;
        logic       exp_walk;

        // 1: idle after reset, highway green forever
        add_rst();
        add(0, 0, 0, 0, 0, 0, 50);

        // 2: car present continuously, side green capped at MAX_GREEN
        add_rst();
        add(0, 1, 0, 0, 0, 0, 8);
        add(0, 1, 0, 0, 1, 0, 3);
        add(0, 1, 0, 0, 2, 0, 2);
        add(0, 1, 0, 0, 4, 0, 20);
        add(0, 1, 0, 0, 5, 0, 3);
        add(0, 1, 0, 0, 6, 0, 2);
        add(0, 1, 0, 0, 0, 0, 8);
        add(0, 1, 0, 0, 1, 0, 1);

        // 3: car only in cycles 12..15, side green gets the minimum
        add_rst();
        add(0, 0, 0, 0, 0, 0, 12);
        add(0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 3);
        add(0, 0, 0, 0, 2, 0, 2);
        add(0, 0, 0, 0, 4, 0, 8);
        add(0, 0, 0, 0, 5, 0, 3);
        add(0, 0, 0, 0, 6, 0, 2);
        add(0, 0, 0, 0, 0, 0, 3);

        // 4: single ped pulse at cycle 2, no cars
        add_rst();
        add(0, 0, 0, 0, 0, 0, 2);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 5);
        add(0, 0, 0, 0, 1, 1, 3);
        add(0, 0, 0, 0, 2, 1, 2);
        add(0, 0, 0, 0, 3, 0, 6);
        add(0, 0, 0, 0, 6, 0, 2);
        add(0, 0, 0, 0, 0, 0, 4);

        // 5: emergency at side green cnt=3, held 30 cycles
        add_rst();
        add(0, 1, 0, 0, 0, 0, 8);
        add(0, 1, 0, 0, 1, 0, 3);
        add(0, 1, 0, 0, 2, 0, 2);
        add(0, 1, 0, 0, 4, 0, 3);
        add(0, 1, 0, 1, 4, 0, 1);
        add(0, 1, 0, 1, 5, 0, 3);
        add(0, 1, 0, 1, 6, 0, 2);
        add(0, 1, 0, 1, 0, 0, 24);
        add(0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 3);

        // 6: clr during side yellow with a pending ped request; full min green afterwards shows cnt restarted
        add_rst();
        add(0, 1, 0, 0, 0, 0, 8);
        add(0, 1, 0, 0, 1, 0, 3);
        add(0, 1, 0, 0, 2, 0, 2);
        add(0, 1, 1, 0, 4, 0, 1);
        add(0, 1, 0, 0, 4, 1, 19);
        add(0, 1, 0, 0, 5, 1, 1);
        add(1, 1, 0, 0, 5, 1, 1);
        add(0, 1, 0, 0, 0, 0, 8);
        add(0, 1, 0, 0, 1, 0, 3);
        add(0, 1, 0, 0, 2, 0, 2);
        add(0, 1, 0, 0, 4, 0, 2);

        // 7: ped held through the walk-entry edge (clear wins), then re-pressed during walk
        add_rst();
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1, 7);
        add(0, 0, 1, 0, 1, 1, 3);
        add(0, 0, 1, 0, 2, 1, 2);
        add(0, 0, 0, 0, 3, 0, 1);
        add(0, 0, 1, 0, 3, 0, 1);
        add(0, 0, 0, 0, 3, 1, 4);
        add(0, 0, 0, 0, 6, 1, 2);
        add(0, 0, 0, 0, 0, 1, 8);
        add(0, 0, 0, 0, 1, 1, 1);

        @(posedge clk);
        #1;
        for (int s = 0; s < segs.size(); s++) begin
            for (int c = 0; c < segs[s].n; c++) begin
                clr        = segs[s].clr;
                car_sensor = segs[s].car;
                ped_req    = segs[s].ped;
                emerg      = segs[s].em;
                if (segs[s].chk) begin
                    exp_hw   = 2'd0;
                    exp_sr   = 2'd0;
                    exp_walk = 1'b0;
                    case (segs[s].ph)
                        3'd0: exp_hw = 2'd2;
                        3'd1: exp_hw = 2'd1;
                        3'd3: exp_walk = 1'b1;
                        3'd4: exp_sr = 2'd2;
                        3'd5: exp_sr = 2'd1;
                        default: ;
                    endcase
                    check("phase", s, c, int'(phase), int'(segs[s].ph));
                    check("highway", s, c, int'(highway), int'(exp_hw));
                    check("small_road", s, c, int'(small_road), int'(exp_sr));
                    check("walk", s, c, int'(walk), int'(exp_walk));
                    check("ped_wait", s, c, int'(ped_wait), int'(segs[s].pw));
                    check("both_heads_nonred", s, c, int'(highway != 2'd0 && small_road != 2'd0), 0);
                end
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Timed phase sequencer for a highway / side-road intersection with a pedestrian crossing of the highway and emergency preemption.
- Replaces sensor-only sequencing with cycle-accurate dwell timers, min/max green limits and all-red clearance intervals.
- Drives the two light heads and the walk lamp directly.
- Top-level controller of the intersection.

Parameters:
- MIN_GREEN, 8, minimum green dwell in cycles (both roads)
- MAX_GREEN, 20, maximum side-road green dwell in cycles
- YELLOW_T, 3, yellow dwell in cycles
- ALLRED_T, 2, all-red clearance dwell in cycles
- WALK_T, 6, pedestrian walk dwell in cycles
- CNT_W, 8, width of the dwell counter

Ports:
- clk  input  1  clock
- clr  input  1  reset
- car_sensor  input  1  side-road vehicle present (level)
- ped_req  input  1  pedestrian button (pulse or level)
- emerg  input  1  emergency preempt to highway (level)
- highway  output  2  highway head: RED=0, YELLOW=1, GREEN=2
- small_road  output  2  side-road head, same encoding
- walk  output  1  pedestrian walk lamp
- ped_wait  output  1  pedestrian request latched, not yet served
- phase  output  3  current state encoding

Behaviour:
- Interface: one clock `clk`. Reset `clr` is synchronous and active-high.
- Reset values: phase=HW_GREEN(0), highway=GREEN, small_road=RED, walk=0, ped_wait=0, dwell counter cnt=0.
- A clr asserted mid-operation behaves identically to power-up reset at the next edge.
- Parameter constraints: all dwell parameters ≥1; MIN_GREEN ≤ MAX_GREEN; every value < 2^CNT_W.
- State encoding: HW_GREEN=0, HW_YELLOW=1, ALLRED_A=2, PED_WALK=3, SR_GREEN=4, SR_YELLOW=5, ALLRED_B=6.
- Illegal state 7 drives both heads RED and moves to ALLRED_B on the next edge.
- Outputs are Moore, decoded from state only:
  - HW_GREEN: highway G / side R
  - HW_YELLOW: highway Y / side R
  - ALLRED_A, ALLRED_B: both R
  - PED_WALK: both R, walk=1
  - SR_GREEN: highway R / side G
  - SR_YELLOW: highway R / side Y
  - walk=0 in every state except PED_WALK.
- Dwell counter cnt:
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 and saturates at all-ones.
  - A timed state with duration T exits when cnt==T-1, giving exactly T cycles of dwell.
- Transitions, evaluated each edge:
  - HW_GREEN → HW_YELLOW when cnt ≥ MIN_GREEN-1 AND (car_sensor OR ped_wait) AND !emerg. Otherwise hold; there is no highway maximum.
  - HW_YELLOW → ALLRED_A after YELLOW_T.
  - ALLRED_A → PED_WALK after ALLRED_T if ped_wait, else → SR_GREEN.
  - PED_WALK → after WALK_T: SR_GREEN if car_sensor, else ALLRED_B. If emerg is high, go immediately to ALLRED_B.
  - SR_GREEN → SR_YELLOW on the first of:
    - emerg
    - cnt ≥ MIN_GREEN-1 AND !car_sensor
    - cnt == MAX_GREEN-1
  - SR_YELLOW → ALLRED_B after YELLOW_T. Yellow is never shortened by emerg.
  - ALLRED_B → HW_GREEN after ALLRED_T.
- Emergency: emerg never skips a yellow or all-red interval. Highway green is held for as long as emerg stays high.
- ped_wait:
  - Set on any cycle with ped_req=1.
  - Cleared on the edge that enters PED_WALK.
  - If ped_req is high on that same edge, the clear wins (the request counts as served).
  - ped_req during PED_WALK, after entry, sets ped_wait again for the next cycle.
- Safety invariant: highway and small_road are never both non-RED in any cycle.

Test Plan:
1. clr=1 for 2 cycles, then all inputs 0 for 50 cycles → phase=0, highway=2, small_road=0, walk=0 throughout.
2. car_sensor held 1 from reset release → sequence repeats:
   - HW_GREEN 8 cycles
   - HW_YELLOW 3
   - ALLRED_A 2
   - SR_GREEN 20 (MAX cap)
   - SR_YELLOW 3
   - ALLRED_B 2
   - HW_GREEN 8
3. car_sensor=1 for cycles 12–15 after reset:
   - HW_YELLOW at cycle 13.
   - SR_GREEN lasts exactly 8 cycles (sensor already low).
   - Then SR_YELLOW.
4. Single-cycle ped_req at cycle 2, no cars:
   - ped_wait=1 from cycle 3.
   - HW_GREEN exits at cnt=7; HW_YELLOW 3, ALLRED_A 2.
   - walk=1 for exactly 6 cycles; ped_wait=0 on walk entry.
   - ALLRED_B 2, then HW_GREEN.
5. emerg=1 at SR_GREEN cnt=3, held 30 cycles, car_sensor=1:
   - SR_YELLOW next cycle (3 cycles), ALLRED_B 2.
   - HW_GREEN held until emerg drops.
   - HW_YELLOW no earlier than the edge after emerg=0.
6. clr pulsed during SR_YELLOW with ped_wait=1 → next edge phase=0, highway=2, small_road=0, ped_wait=0, cnt=0.
